xor_dut_scheduler: RTL

Arbitrating front-end that shares one single-slot XOR datapath (A/B operand handshake in, Y result handshake out) among NREQ requesters. It accepts one operand pair at a time from a round-robin-selected requester, sequences the A and B operand handshakes into the datapath, and holds the operands stable until the result returns. It then forwards the result tagged with the owner's index, and a watchdog recovers from a result that never arrives.

---
 rtl/xor_dut_scheduler_pkg.sv | 20 ++
 rtl/xor_dut_scheduler_arb.sv | 36 +++
 rtl/xor_dut_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xor_dut_scheduler_pkg.sv
// Shared definitions for the XOR datapath scheduler.
//   sched_state_t   : FSM state encoding, also exposed on the debug port
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
//   calc_idw()      : requester-index width for a given requester count
package xor_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    // A single requester still needs a one-bit index.
    function automatic int calc_idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/xor_dut_scheduler_arb.sv
// Round-robin arbiter, purely combinational.
//   i_req   : request vector
//   i_last  : index of the most recently granted requester
//   o_grant : one-hot grant for the first requester after i_last (wrapping)
//   o_idx   : encoded index of that grant (0 when no request)
module rr_arbiter
    import xor_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    int w_pos;

    // Walk the candidates from farthest to nearest so that the nearest
    // requester after i_last is the one that sticks.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = (int'(i_last) + k) % NREQ;
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/xor_dut_scheduler.sv
// Shares one single-slot XOR datapath among NREQ requesters.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   i_en                    : allow new grants (an op in flight always completes)
//   i_req_valid/a/b         : per-requester operand pair
//   o_req_ready             : one-hot acceptance
//   o_rsp_valid/data/id     : result towards the owning requester
//   i_rsp_ready             : result consumer ready
//   o_dut_a/b_data/enable   : operand strobes and registered operands to datapath
//   i_dut_a/b_ready         : datapath operand slots free
//   i_dut_y_data/enable     : datapath result
//   o_dut_y_ready           : result acknowledge to datapath
//   o_err, i_err_clr        : sticky watchdog flag and its clear
//   o_state                 : current FSM state (debug)
//
// Handshakes: a transfer happens in a cycle where valid (or enable) and
// ready are both high at the rising edge; neither side may make its
// valid depend on the other side's ready.
module xor_dut_scheduler
    import xor_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = calc_idw(NREQ),
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [NREQ-1:0] i_req_a,
    input  logic [NREQ-1:0] i_req_b,
    output logic [NREQ-1:0] o_req_ready,
    output logic            o_rsp_valid,
    output logic            o_rsp_data,
    output logic [IDW-1:0]  o_rsp_id,
    input  logic            i_rsp_ready,
    output logic            o_dut_a_data,
    output logic            o_dut_b_data,
    output logic            o_dut_a_enable,
    output logic            o_dut_b_enable,
    input  logic            i_dut_a_ready,
    input  logic            i_dut_b_ready,
    input  logic            i_dut_y_data,
    input  logic            i_dut_y_enable,
    output logic            o_dut_y_ready,
    output logic            o_err,
    input  logic            i_err_clr,
    output sched_state_t    o_state
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    sched_state_t   r_state;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_owner;
    logic           r_a_done;
    logic           r_b_done;
    logic [WDW-1:0] r_wd;
    logic           r_err;
    logic           r_a_data;
    logic           r_b_data;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_idle;
    logic            w_issue;
    logic            w_wait;
    logic            w_accept;
    logic            w_a_take;
    logic            w_b_take;
    logic            w_both;
    logic            w_y_hs;
    logic            w_timeout;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_wait   = (r_state == ST_WAIT);
    assign w_accept = w_idle & i_en & (|i_req_valid);
    assign w_a_take = w_issue & ~r_a_done & i_dut_a_ready;
    assign w_b_take = w_issue & ~r_b_done & i_dut_b_ready;
    // Second operand accepted this cycle, whichever order they came in.
    assign w_both   = (r_a_done | w_a_take) & (r_b_done | w_b_take);
    assign w_y_hs   = w_wait & i_dut_y_enable & i_rsp_ready;
    // A result handshake on the last allowed cycle still completes normally.
    assign w_timeout = (w_issue | w_wait) & (r_wd == WDW'(TIMEOUT - 1)) & ~w_y_hs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_last   <= IDW'(NREQ - 1);
            r_owner  <= '0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_wd     <= '0;
            r_err    <= 1'b0;
            r_a_data <= 1'b0;
            r_b_data <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_data <= i_req_a[w_gidx];
                        r_b_data <= i_req_b[w_gidx];
                        r_owner  <= w_gidx;
                        r_last   <= w_gidx;
                        r_a_done <= 1'b0;
                        r_b_done <= 1'b0;
                        r_wd     <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_a_take) r_a_done <= 1'b1;
                    if (w_b_take) r_b_done <= 1'b1;
                    if (w_timeout)   r_state <= ST_IDLE;
                    else if (w_both) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_y_hs || w_timeout) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_timeout)      r_err <= 1'b1;
            else if (i_err_clr) r_err <= 1'b0;
        end
    end

    // Handshake outputs are held low while reset is asserted so an aborted
    // op cannot leak a strobe or response.
    assign o_req_ready    = (reset_n && w_idle && i_en) ? w_grant : '0;
    assign o_dut_a_enable = reset_n & w_issue & ~r_a_done;
    assign o_dut_b_enable = reset_n & w_issue & ~r_b_done;
    assign o_rsp_valid    = reset_n & w_wait & i_dut_y_enable;
    assign o_rsp_data     = reset_n & w_wait & i_dut_y_data;
    assign o_rsp_id       = r_owner;
    // Outside WAIT any result is stale and is acknowledged so it drains.
    assign o_dut_y_ready  = reset_n & (w_wait ? i_rsp_ready : (w_idle | w_issue));
    assign o_dut_a_data   = r_a_data;
    assign o_dut_b_data   = r_b_data;
    assign o_err          = r_err;
    assign o_state        = r_state;

endmodule
